serializador_matriz: RTL and testbench

SERIALIZADOR_MATRIZ -- requirements
Module: serializador_matriz

---
 rtl/matriz_pkg.sv | 26 ++
 rtl/contador_matriz.sv | 46 ++++
 rtl/serializador_matriz.sv | 105 ++++++++++
 tb/tb_serializador_matriz.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared definitions for the matrix serializer: element/bus sizing,
// size codes, FSM state type and the size-code decode helper.
package matriz_pkg;

  localparam int unsigned ELEM_W  = 8;
  localparam int unsigned MAX_DIM = 5;
  localparam int unsigned BUS_W   = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int unsigned CNT_W   = 3;

  localparam logic [1:0] SIZE_2X2 = 2'b00;
  localparam logic [1:0] SIZE_3X3 = 2'b01;
  localparam logic [1:0] SIZE_4X4 = 2'b10;
  localparam logic [1:0] SIZE_5X5 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Size code to matrix dimension: 00->2 ... 11->5.
  function automatic logic [CNT_W-1:0] dim_from_code(input logic [1:0] code);
    return {1'b0, code} + 3'd2;
  endfunction

endpackage

// File: rtl/contador_matriz.sv
// Row/column position counter for row-major traversal of a dim x dim matrix.
//   clk, rst_n  : clock, async active-low reset
//   clear       : return to (0,0)
//   advance     : step to the next element (col first, wrapping into row)
//   dim         : current matrix dimension (2..5)
//   row, col    : current coordinates
//   last        : current position is (dim-1, dim-1)
module contador_matriz (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       advance,
  input  logic [2:0] dim,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  logic [2:0] r_row;
  logic [2:0] r_col;
  logic [2:0] w_max;

  assign w_max = dim - 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (advance) begin
      if (r_col == w_max) begin
        r_col <= '0;
        r_row <= r_row + 3'd1;
      end else begin
        r_col <= r_col + 3'd1;
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign last = (r_row == w_max) && (r_col == w_max);

endmodule

// File: rtl/serializador_matriz.sv
// Captures a packed square matrix (2x2..5x5) on start and streams its
// elements row-major over a valid/ready interface, one per cycle when the
// consumer is ready, followed by a one-cycle done pulse.
//   clk, rst_n            : clock, async active-low reset
//   start                 : capture request, honoured only when idle
//   matrix_in             : packed row-major elements, element i at [i*ELEM_W +: ELEM_W]
//   matrix_size           : 00=2x2, 01=3x3, 10=4x4, 11=5x5
//   busy                  : a captured matrix is streaming or finishing
//   out_valid/out_ready   : element handshake
//   out_elem, out_row/col : element value and coordinates
//   out_last              : final element of the matrix
//   done                  : pulse after the final transfer
module serializador_matriz #(
  parameter int unsigned ELEM_W  = matriz_pkg::ELEM_W,
  parameter int unsigned MAX_DIM = matriz_pkg::MAX_DIM
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_in,
  input  logic [1:0]                          matrix_size,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ELEM_W-1:0]                   out_elem,
  output logic [2:0]                          out_row,
  output logic [2:0]                          out_col,
  output logic                                out_last,
  output logic                                done
);

  localparam int unsigned BUS_W = MAX_DIM * MAX_DIM * ELEM_W;

  matriz_pkg::state_e r_state;
  logic [BUS_W-1:0]   r_matrix;
  logic [1:0]         r_size;

  logic [2:0] w_dim;
  logic [2:0] w_row;
  logic [2:0] w_col;
  logic       w_last;
  logic       w_stream;
  logic       w_clear;
  logic       w_advance;
  logic [4:0] w_idx;

  assign w_dim     = matriz_pkg::dim_from_code(r_size);
  assign w_stream  = (r_state == matriz_pkg::ST_STREAM);
  assign w_clear   = !w_stream;
  assign w_advance = w_stream && out_ready && !w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= matriz_pkg::ST_IDLE;
      r_matrix <= '0;
      r_size   <= '0;
    end else begin
      case (r_state)
        matriz_pkg::ST_IDLE: begin
          if (start) begin
            r_matrix <= matrix_in;
            r_size   <= matrix_size;
            r_state  <= matriz_pkg::ST_STREAM;
          end
        end
        matriz_pkg::ST_STREAM: begin
          if (out_ready && w_last) begin
            r_state <= matriz_pkg::ST_DONE;
          end
        end
        matriz_pkg::ST_DONE: begin
          r_state <= matriz_pkg::ST_IDLE;
        end
        default: begin
          r_state <= matriz_pkg::ST_IDLE;
        end
      endcase
    end
  end

  contador_matriz u_contador (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_clear),
    .advance (w_advance),
    .dim     (w_dim),
    .row     (w_row),
    .col     (w_col),
    .last    (w_last)
  );

  // Flat element index; the counter bounds it to dim*dim-1 <= 24.
  assign w_idx = ({2'b00, w_row} * {2'b00, w_dim}) + {2'b00, w_col};

  // Reading straight from the snapshot keeps the element stable across
  // stalls and yields zero after reset (snapshot and counter both clear).
  assign out_elem  = r_matrix[w_idx*ELEM_W +: ELEM_W];
  assign out_row   = w_row;
  assign out_col   = w_col;
  assign out_valid = w_stream;
  assign out_last  = w_stream && w_last;
  assign done      = (r_state == matriz_pkg::ST_DONE);
  assign busy      = (r_state != matriz_pkg::ST_IDLE);

endmodule

// File: tb/tb_serializador_matriz.sv
module tb_serializador_matriz;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [199:0] matrix_in;
  logic [1:0]   matrix_size;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_elem;
  logic [2:0]   out_row;
  logic [2:0]   out_col;
  logic         out_last;
  logic         done;

  int n_checks = 0;
  int n_err    = 0;

  serializador_matriz #(.ELEM_W(8), .MAX_DIM(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .matrix_in   (matrix_in),
    .matrix_size (matrix_size),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_elem    (out_elem),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_last    (out_last),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 = ready always high, 1 = ready toggling 1,0,..., 2 = random ready.
  task automatic run_stream(input logic [1:0] code, input logic [199:0] mat,
                            input int mode, input bit scramble, input bit poke_start);
    int d;
    int n;
    int k;
    int cyc;
    bit r;
    logic [17:0] exp;
    d = int'(code) + 2;
    n = d * d;
    k = 0;
    cyc = 0;
    start = 1'b1;
    matrix_in = mat;
    matrix_size = code;
    @(negedge clk);
    start = poke_start;
    if (scramble) begin
      matrix_in = {25{8'h7F}};
      matrix_size = ~code;
    end
    while (k < n && cyc < 4 * n + 8) begin
      // Reference: element k of a row-major d x d matrix.
      exp = {1'b1, 1'b0, 1'b1, (k == n - 1), 3'(k / d), 3'(k % d), mat[k*8 +: 8]};
      chk("beat", {busy, done, out_valid, out_last, out_row, out_col, out_elem}, 32'(exp));
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      @(negedge clk);
      cyc++;
      if (r) k++;
    end
    chk("beat_count", 32'(k), 32'(n));
    out_ready = 1'b0;
    chk("done_cycle", {busy, done, out_valid, out_last}, 4'b1100);
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", {busy, done, out_valid}, 3'b000);
    @(negedge clk);
    chk("stay_idle", {busy, done, out_valid}, 3'b000);
  endtask

  logic [199:0] m;
  int vals[4];

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    matrix_in = '0;
    matrix_size = 2'b00;
    #1;
    chk("reset_state", {busy, done, out_valid, out_last, out_row, out_col, out_elem}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 2x2 signed values, full throughput.
    vals = '{10, -20, 30, -40};
    m = '0;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = 8'(vals[i]);
    run_stream(2'b00, m, 0, 1'b0, 1'b0);

    // 3x3 ramp 0,5,..,40 with toggling ready.
    m = '0;
    for (int i = 0; i < 9; i++) m[i*8 +: 8] = 8'(i * 5);
    run_stream(2'b01, m, 1, 1'b0, 1'b0);

    // 5x5 descending 0..-24; inputs scrambled after capture.
    m = '0;
    for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(-i);
    run_stream(2'b11, m, 0, 1'b1, 1'b0);

    // Extra start requests during STREAM and DONE must be dropped.
    m = '0;
    for (int i = 0; i < 9; i++) m[i*8 +: 8] = 8'($urandom);
    run_stream(2'b01, m, 2, 1'b0, 1'b1);

    // Extremes pass through unchanged.
    vals = '{-128, 127, -1, 0};
    m = '0;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = 8'(vals[i]);
    run_stream(2'b00, m, 0, 1'b0, 1'b0);

    // Reset in the middle of a 4x4 stream.
    m = '0;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'(i + 1);
    start = 1'b1;
    matrix_in = m;
    matrix_size = 2'b10;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_beat", {out_valid, out_row, out_col, out_elem}, {1'b1, 3'd0, 3'd2, 8'd3});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, done, out_valid, out_last, out_row, out_col, out_elem}, 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_reset", {busy, done, out_valid}, 3'b000);
    end
    rst_n = 1'b1;
    // First start immediately after release, streaming from (0,0).
    m = '0;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'($urandom);
    run_stream(2'b10, m, 0, 1'b0, 1'b0);

    // Random sizes, contents and back-pressure.
    for (int t = 0; t < 6; t++) begin
      m = '0;
      for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'($urandom);
      run_stream(2'($urandom_range(0, 3)), m, 2, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
